// File: rtl/timer_bus_arbiter.sv
// timer_bus_arbiter: shares the timer device bus between a CPU port (0) and an
// auxiliary master port (1). Decodes two 3-word timer windows, covers the timers'
// one-cycle registered read latency, and registers the timer IRQs into HWInt.
// Optional build macro: ARB_FIXED_PRIO_EN (port 0 always wins a simultaneous
// request); without it arbitration is round-robin on the last granted port.
module timer_bus_arbiter #(
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic        dev_we0,
  output logic        dev_we1,
  input  logic [31:0] dev_rdata0,
  input  logic [31:0] dev_rdata1,
  input  logic        irq0,
  input  logic        irq1,
  output logic [5:0]  hwint
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        rd_port_q, rd_port_d;
  logic [1:0]  rd_hit_q, rd_hit_d;   // {hit TC1, hit TC0} of the pending read
  logic [1:0]  hwint_q;

  logic        win;                  // 0 = port 0 wins, 1 = port 1 wins
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        hit0, hit1;

  // Word-granular window check: CTRL, PRESET, COUNT at base+0/4/8; slot 3 is a hole.
  function automatic logic in_window(input logic [31:0] a, input logic [31:0] base);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    return (wa >= base) && (wa <= base + 32'd8) && (wa[3:2] != 2'b11);
  endfunction

  // Winner selection and mux of the winning port onto the shared bus fields
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    win = ~req0;
`else
    if (req0 && req1) win = ~last_q;
    else              win = req1;
`endif
    sel_we    = win ? we1    : we0;
    sel_addr  = win ? addr1  : addr0;
    sel_wdata = win ? wdata1 : wdata0;
    hit0      = in_window(sel_addr, TC0_BASE);
    hit1      = in_window(sel_addr, TC1_BASE);
  end

  // Next state and bus outputs; everything is forced quiet while reset is high
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    rdata_d   = rdata_q;
    rd_addr_d = rd_addr_q;
    rd_port_d = rd_port_q;
    rd_hit_d  = rd_hit_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata     = 32'd0;
    err       = 1'b0;
    dev_addr  = 32'd0;
    dev_wdata = 32'd0;
    dev_we0   = 1'b0;
    dev_we1   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0      = ~win;
          gnt1      = win;
          last_d    = win;
          dev_addr  = sel_addr;
          dev_wdata = sel_wdata;
          if (sel_we) begin
            // Writes complete in the grant cycle, so IDLE can grant again next cycle
            dev_we0 = hit0;
            dev_we1 = hit1;
            err     = ~(hit0 | hit1);
          end else begin
            rd_addr_d = sel_addr;
            rd_port_d = win;
            rd_hit_d  = {hit1, hit0};
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Timer has registered its data from the address presented in the grant cycle
        dev_addr = rd_addr_q;
        if (rd_hit_q[0])      rdata_d = dev_rdata0;
        else if (rd_hit_q[1]) rdata_d = dev_rdata1;
        else                  rdata_d = 32'd0;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        rvalid0 = ~rd_port_q;
        rvalid1 = rd_port_q;
        rdata   = rdata_q;
        err     = ~(|rd_hit_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      rdata     = 32'd0;
      err       = 1'b0;
      dev_addr  = 32'd0;
      dev_wdata = 32'd0;
      dev_we0   = 1'b0;
      dev_we1   = 1'b0;
    end
  end

  // Control state, read-data register and IRQ sampling
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      rdata_q <= 32'd0;
      hwint_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      hwint_q <= {irq1, irq0};
    end
  end

  // Pending-read context; only consulted in RD_WAIT/RD_RESP, so no reset needed
  always_ff @(posedge clk) begin
    rd_addr_q <= rd_addr_d;
    rd_port_q <= rd_port_d;
    rd_hit_q  <= rd_hit_d;
  end

  assign hwint = {4'b0000, hwint_q};

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Self-checking bench for timer_bus_arbiter with a behavioural model of two
// 3-register timers and an expected-register image kept by the bench.
module tb_timer_bus_arbiter;

  localparam logic [31:0] TC0 = 32'h0000_7F00;
  localparam logic [31:0] TC1 = 32'h0000_7F10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err;
  logic [31:0] rdata, dev_addr, dev_wdata;
  logic        dev_we0, dev_we1;
  logic [31:0] dev_rdata0, dev_rdata1;
  logic        irq0, irq1;
  logic [5:0]  hwint;

  logic [31:0] tc0_mem [3];
  logic [31:0] tc1_mem [3];
  logic [31:0] exp0 [3];
  logic [31:0] exp1 [3];

  int total = 0;
  int bad = 0;
  int exp_last;

  timer_bus_arbiter #(.TC0_BASE(TC0), .TC1_BASE(TC1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_we0(dev_we0), .dev_we1(dev_we1),
    .dev_rdata0(dev_rdata0), .dev_rdata1(dev_rdata1),
    .irq0(irq0), .irq1(irq1), .hwint(hwint)
  );

  always #5 clk = ~clk;

  // Word index inside a window, or -1 when the address is not a timer register
  function automatic int widx(input logic [31:0] a, input logic [31:0] base);
    logic [31:0] off;
    if (a < base) return -1;
    off = (a - base) / 4;
    if (off > 2) return -1;
    return int'(off);
  endfunction

  // Timer devices: write at the edge, read data registered from dev_addr
  always @(posedge clk) begin : tc_model
    int k0, k1;
    k0 = widx(dev_addr, TC0);
    k1 = widx(dev_addr, TC1);
    if (dev_we0 && k0 >= 0) tc0_mem[k0] <= dev_wdata;
    if (dev_we1 && k1 >= 0) tc1_mem[k1] <= dev_wdata;
    dev_rdata0 <= (k0 >= 0) ? tc0_mem[k0] : 32'hBAD0_0000;
    dev_rdata1 <= (k1 >= 0) ? tc1_mem[k1] : 32'hBAD1_0000;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_win();
`ifdef ARB_FIXED_PRIO_EN
    return 0;
`else
    return (exp_last == 0) ? 1 : 0;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (widx(a, TC0) >= 0) return exp0[widx(a, TC0)];
    if (widx(a, TC1) >= 0) return exp1[widx(a, TC1)];
    return 32'd0;
  endfunction

  function automatic bit is_miss(input logic [31:0] a);
    return (widx(a, TC0) < 0) && (widx(a, TC1) < 0);
  endfunction

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
    if (widx(a, TC0) >= 0) exp0[widx(a, TC0)] = d;
    if (widx(a, TC1) >= 0) exp1[widx(a, TC1)] = d;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_last = 1;
  endtask

  // Single-port access with full cycle-by-cycle checking
  task automatic do_access(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] erd;
    bit miss;
    miss = is_miss(a);
    erd  = exp_read(a);
    @(negedge clk);
    set_port(p, 1'b1, w, a, d);
    #1;
    total++;
    if (gnt0 !== (p == 0) || gnt1 !== (p == 1))
      $display("FAIL grant p%0d: gnt0=%b gnt1=%b", p, gnt0, gnt1);
    if (gnt0 !== (p == 0) || gnt1 !== (p == 1)) bad++;
    exp_last = p;
    if (w) begin
      total++;
      if (dev_we0 !== (widx(a, TC0) >= 0) || dev_we1 !== (widx(a, TC1) >= 0) ||
          err !== miss || dev_wdata !== d || dev_addr !== a) begin
        bad++;
        $display("FAIL write a=%h: we0=%b we1=%b err=%b addr=%h wdata=%h, want miss=%b wdata=%h",
                 a, dev_we0, dev_we1, err, dev_addr, dev_wdata, miss, d);
      end
      exp_write(a, d);
      @(negedge clk);
      set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
    end else begin
      total++;
      if (dev_we0 !== 1'b0 || dev_we1 !== 1'b0 || err !== 1'b0 || dev_addr !== a) begin
        bad++;
        $display("FAIL read grant a=%h: we0=%b we1=%b err=%b addr=%h", a, dev_we0, dev_we1, err, dev_addr);
      end
      @(negedge clk);
      set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      total++;
      if (gnt0 || gnt1 || rvalid0 || rvalid1 || err || dev_addr !== a) begin
        bad++;
        $display("FAIL read wait a=%h: gnt=%b%b rvalid=%b%b err=%b addr=%h",
                 a, gnt1, gnt0, rvalid1, rvalid0, err, dev_addr);
      end
      @(negedge clk);
      #1;
      total++;
      if (rvalid0 !== (p == 0) || rvalid1 !== (p == 1) || rdata !== erd ||
          err !== miss || gnt0 || gnt1) begin
        bad++;
        $display("FAIL read resp a=%h: rvalid=%b%b rdata=%h err=%b gnt=%b%b, want p%0d rdata=%h err=%b",
                 a, rvalid1, rvalid0, rdata, err, gnt1, gnt0, p, erd, miss);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    irq0 = 1'b1; irq1 = 1'b1;
    set_port(0, 1'b1, 1'b1, TC0, 32'h1234);
    set_port(1, 1'b1, 1'b0, TC1, 32'h5678);
    #1;
    total++;
    if (gnt0 || gnt1 || rvalid0 || rvalid1 || dev_we0 || dev_we1 || err ||
        dev_addr !== 32'd0 || dev_wdata !== 32'd0 || rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset outputs: gnt=%b%b rv=%b%b we=%b%b err=%b addr=%h wdata=%h rdata=%h",
               gnt1, gnt0, rvalid1, rvalid0, dev_we1, dev_we0, err, dev_addr, dev_wdata, rdata);
    end
    @(negedge clk);
    #1;
    total++;
    if (hwint !== 6'd0) begin
      bad++;
      $display("FAIL reset hwint: got %b want 000000", hwint);
    end
    irq0 = 1'b0; irq1 = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    exp_last = 1;
  endtask

  task automatic test_init_regs();
    for (int k = 0; k < 3; k++) begin
      do_access(0, 1'b1, TC0 + 32'(4 * k), $urandom);
      do_access(1, 1'b1, TC1 + 32'(4 * k), $urandom);
    end
  endtask

  task automatic test_directed();
    do_access(0, 1'b1, 32'h0000_7F00, 32'h9);
    do_access(1, 1'b1, 32'h0000_7F14, 32'h64);
    do_access(1, 1'b0, 32'h0000_7F14, 32'h0);
    do_access(0, 1'b0, 32'h0000_7F0C, 32'h0);
    do_access(0, 1'b1, 32'h0000_8000, 32'hABCD);
    do_access(0, 1'b0, 32'h0000_7F00, 32'h0);
  endtask

  // Both ports hold writes for four cycles right after reset
  task automatic test_round_robin();
    int w;
    logic [31:0] a[2];
    logic [31:0] d[2];
    apply_reset();
    a[0] = TC0 + 32'h4; d[0] = $urandom;
    a[1] = TC1 + 32'h8; d[1] = $urandom;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_port(0, 1'b1, 1'b1, a[0], d[0]);
      set_port(1, 1'b1, 1'b1, a[1], d[1]);
      #1;
      w = exp_win();
      total++;
      if (gnt0 !== (w == 0) || gnt1 !== (w == 1) || dev_we0 !== (w == 0) ||
          dev_we1 !== (w == 1) || dev_wdata !== d[w]) begin
        bad++;
        $display("FAIL arbitration cycle %0d: gnt=%b%b we=%b%b wdata=%h, want port %0d",
                 c, gnt1, gnt0, dev_we1, dev_we0, dev_wdata, w);
      end
      exp_last = w;
      exp_write(a[w], d[w]);
    end
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Simultaneous read/write: loser stays pending until the next IDLE cycle
  task automatic test_pending(input bit p0_read);
    int w, l, got;
    bit pw[2];
    logic [31:0] pa[2];
    logic [31:0] pd[2];
    logic [31:0] rdw, rdl;
    pw[0] = !p0_read; pw[1] = p0_read;
    pa[0] = TC0 + 32'(4 * $urandom_range(0, 2)); pd[0] = $urandom;
    pa[1] = TC1 + 32'(4 * $urandom_range(0, 2)); pd[1] = $urandom;
    w = exp_win(); l = 1 - w;
    rdw = exp_read(pa[w]);
    @(negedge clk);
    set_port(0, 1'b1, pw[0], pa[0], pd[0]);
    set_port(1, 1'b1, pw[1], pa[1], pd[1]);
    #1;
    total++;
    if (gnt0 !== (w == 0) || gnt1 !== (w == 1)) begin
      bad++;
      $display("FAIL pending winner: gnt=%b%b want port %0d", gnt1, gnt0, w);
    end
    exp_last = w;
    if (pw[w]) exp_write(pa[w], pd[w]);
    got = 0;
    for (int c = 1; c <= 6 && got == 0; c++) begin
      @(negedge clk);
      if (c == 1) set_port(w, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      if (!pw[w] && c == 2) begin
        total++;
        if (((w == 0) ? rvalid0 : rvalid1) !== 1'b1 || rdata !== rdw) begin
          bad++;
          $display("FAIL pending winner read: rvalid=%b%b rdata=%h want %h", rvalid1, rvalid0, rdata, rdw);
        end
      end
      if (gnt0 || gnt1) begin
        got = c;
        total++;
        if (gnt0 !== (l == 0) || gnt1 !== (l == 1)) begin
          bad++;
          $display("FAIL pending loser grant: gnt=%b%b want port %0d", gnt1, gnt0, l);
        end
      end
    end
    total++;
    if (got != (pw[w] ? 1 : 3)) begin
      bad++;
      $display("FAIL pending latency: got %0d cycles want %0d", got, pw[w] ? 1 : 3);
    end
    exp_last = l;
    rdl = exp_read(pa[l]);
    if (pw[l]) exp_write(pa[l], pd[l]);
    @(negedge clk);
    set_port(l, 1'b0, 1'b0, 32'd0, 32'd0);
    if (!pw[l] && got != 0) begin
      @(negedge clk);
      #1;
      total++;
      if (((l == 0) ? rvalid0 : rvalid1) !== 1'b1 || rdata !== rdl) begin
        bad++;
        $display("FAIL pending loser read: rvalid=%b%b rdata=%h want %h", rvalid1, rvalid0, rdata, rdl);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int p, sel;
      bit w;
      logic [31:0] a;
      p = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1:    a = TC0 + 32'(4 * $urandom_range(0, 3));
        2, 3:    a = TC1 + 32'(4 * $urandom_range(0, 3));
        4:       a = 32'h0000_8000 + 32'(4 * $urandom_range(0, 7));
        default: a = $urandom;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      do_access(p, w, a, $urandom);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, TC0 + 32'h8, 32'd0);
    #1;
    total++;
    if (gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL abort grant: gnt0=%b want 1", gnt0);
    end
    @(negedge clk);
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_last = 1;
    set_port(0, 1'b1, 1'b1, TC0, d);
    #1;
    total++;
    if (rvalid0 || rvalid1 || gnt0 !== 1'b1 || dev_we0 !== 1'b1 || dev_wdata !== d) begin
      bad++;
      $display("FAIL abort after reset: rvalid=%b%b gnt0=%b we0=%b wdata=%h want gnt0=1 we0=1 wdata=%h",
               rvalid1, rvalid0, gnt0, dev_we0, dev_wdata, d);
    end
    exp_last = 0;
    exp_write(TC0, d);
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    total++;
    if (rvalid0 || rvalid1 || gnt0 || gnt1) begin
      bad++;
      $display("FAIL abort quiet: rvalid=%b%b gnt=%b%b want all 0", rvalid1, rvalid0, gnt1, gnt0);
    end
  endtask

  task automatic test_irq();
    logic [1:0] prev;
    @(negedge clk);
    irq1 = 1'b1;
    #1;
    total++;
    if (hwint !== 6'b000000) begin
      bad++;
      $display("FAIL irq1 rise same cycle: hwint=%b want 000000", hwint);
    end
    @(negedge clk);
    #1;
    total++;
    if (hwint !== 6'b000010) begin
      bad++;
      $display("FAIL irq1 rise: hwint=%b want 000010", hwint);
    end
    irq1 = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (hwint !== 6'b000000) begin
      bad++;
      $display("FAIL irq1 fall: hwint=%b want 000000", hwint);
    end
    prev = 2'b00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (hwint !== {4'b0000, prev}) begin
        bad++;
        $display("FAIL irq random %0d: hwint=%b want %b", c, hwint, {4'b0000, prev});
      end
      irq0 = 1'($urandom_range(0, 1));
      irq1 = 1'($urandom_range(0, 1));
      prev = {irq1, irq0};
    end
    irq0 = 1'b0; irq1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    irq0 = 1'b0; irq1 = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_last = 1;
    repeat (2) @(negedge clk);
    test_reset();
    test_init_regs();
    test_directed();
    test_round_robin();
    test_pending(1'b1);
    test_pending(1'b0);
    test_pending(1'b1);
    test_random();
    test_reset_abort();
    test_irq();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_bus_arbiter.md
# timer_bus_arbiter

Shares the memory-mapped timer bus between two requesters: port 0 (CPU store/load path) and port 1 (auxiliary master, e.g. debug/DMA). It sequences each access onto the single device bus, decodes the two timer windows, and handles the one-cycle registered read latency of the timers. It also registers the timer interrupt lines into the CPU hardware-interrupt vector. It sits between the CPU bridge and timer devices TC0 and TC1.

## Interface
- `TC0_BASE`, default 32'h0000_7F00: base of timer 0 window (3 words: CTRL, PRESET, COUNT)
- `TC1_BASE`, default 32'h0000_7F10: base of timer 1 window
- `clk` input 1: single clock; all state updates on posedge
- `reset` input 1: synchronous, active-high
- `req0`, `req1` input 1: access request, held until granted
- `we0`, `we1` input 1: 1 = write, 0 = read
- `addr0`, `addr1` input 32: byte address, word aligned
- `wdata0`, `wdata1` input 32: write data
- `gnt0`, `gnt1` output 1: one-cycle grant pulse; the request is consumed
- `rvalid0`, `rvalid1` output 1: one-cycle read-response pulse
- `rdata` output 32: read data, valid while `rvalid0` or `rvalid1` is high
- `err` output 1: one-cycle pulse on an out-of-window access
- `dev_addr` output 32: shared device address
- `dev_wdata` output 32: shared device write data
- `dev_we0`, `dev_we1` output 1: per-timer write enable
- `dev_rdata0`, `dev_rdata1` input 32: timer read data. The timer registers this data from `dev_addr` at the edge, so it is valid the cycle after the address is presented.
- `irq0`, `irq1` input 1: timer interrupt lines
- `hwint` output 6: CPU HWInt[7:2]. Bit 0 is registered `irq0`, bit 1 is registered `irq1`, bits 5:2 are 0.

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP.
- IDLE, no request: outputs stay quiet; `dev_we*` = 0.
- IDLE with a request: the arbiter picks a winner and pulses its `gnt` in the same cycle. `dev_addr` and `dev_wdata` are driven combinationally from the winner.
- Arbitration is round-robin on the `last` register (reset 1, so port 0 wins first). On a simultaneous request, the port that is not `last` wins. `last` updates on every grant.
- Address decode: the hit window is [base, base+8] with `addr[1:0]` ignored.
  - Any other address is a miss.
  - `addr[3:2]` = 11 inside a window is also a miss.
- Write hit: `dev_weN` = 1 for the granted cycle only. The FSM stays in IDLE, so back-to-back writes are possible every cycle.
- Write miss: no `dev_we`; `err` pulses in the grant cycle.
- Read, hit or miss: the granted address and device index are latched, then the FSM goes to RD_WAIT.
- RD_WAIT: `dev_addr` holds the latched address. At the edge, `rdata_q` captures `dev_rdata` of the latched device, or 0 on a miss. The FSM goes to RD_RESP.
- RD_RESP:
  - `rvalidN` = 1 for the latched port; `rdata` = `rdata_q`.
  - `err` = 1 if the read was a miss.
  - The FSM returns to IDLE. No grant is issued in RD_WAIT or RD_RESP.
- Outside RD_RESP, `rdata` = 0.
- `hwint[1:0]` <= {`irq1`, `irq0`} every cycle; no masking here.

## Timing
- Reset values:
  - Registers: state IDLE, `last` 1, `rdata_q` 0, `hwint` 0.
  - Combinational outputs while `reset` is high: `gnt*`, `rvalid*`, `dev_we*`, `err` = 0; `dev_addr`, `dev_wdata` = 0.
- Write latency: grant and device write happen in the same cycle; the register updates at that edge.
- Read latency: grant in cycle N, RD_WAIT in N+1, `rvalid` in N+2. A new grant is possible at the earliest in N+3.
- A requester must hold `req`, `we`, `addr`, `wdata` stable until its `gnt`. It may drop or change them in the cycle after `gnt`.
- Reset during RD_WAIT or RD_RESP aborts the read: no `rvalid` is issued, and the FSM is in IDLE the next cycle.
- A `req` on the losing port stays pending. It is granted at the next IDLE cycle if it is still asserted.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: fixed priority. Port 0 always wins a simultaneous request; `last` is unused.
- `ARB_FIXED_PRIO_EN` undefined: round-robin as described above.

## Test plan
- Port 0 writes 32'h9 to 0x7F00 -> `gnt0` and `dev_we0` = 1 in the same cycle, `dev_wdata` = 32'h9, `dev_we1` = 0, `err` = 0.
- Port 1 reads 0x7F14 with the TC1 model returning PRESET 32'h64 -> `gnt1` in cycle N, `rvalid1` = 1 with `rdata` = 32'h64 in N+2, and no grant in N+1 or N+2.
- `req0` and `req1` writes held together for 4 cycles after reset -> grants alternate 0,1,0,1. With `ARB_FIXED_PRIO_EN` defined -> 0,0,0,0.
- Out-of-window accesses:
  - Port 0 reads 0x7F0C -> `rvalid0` in N+2 with `rdata` = 0 and `err` = 1.
  - Port 0 writes 0x8000 -> `err` = 1 in the grant cycle, no `dev_we`.
- `reset` asserted in the RD_WAIT cycle -> no `rvalid` next cycle; a new `req0` write is granted in the first cycle after reset deasserts.
- `irq1` rises at cycle K -> `hwint` = 6'b000010 from cycle K+1; `irq1` falls -> `hwint` = 0 one cycle later.
